// File: rtl/update_lane_merge.sv
// Packs two bubbly update lanes into one in-order circular buffer
// and presents them as a single valid/ready stream with overflow flag.
module update_lane_merge #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                InputValid_A,
    input  logic                InputValid_B,
    input  logic [DATA_W-1:0]   InDestVid_A,
    input  logic [DATA_W-1:0]   InDestVid_B,
    input  logic [DATA_W-1:0]   InUpdate_A,
    input  logic [DATA_W-1:0]   InUpdate_B,
    output logic                InReady,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [DATA_W-1:0]   OutDestVid,
    output logic [DATA_W-1:0]   OutUpdate,
    output logic [ADDR_W:0]     Count,
    output logic                Overflow
);

    logic [DATA_W-1:0] dest_mem [DEPTH];
    logic [DATA_W-1:0] upd_mem  [DEPTH];

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;

    logic [ADDR_W:0]   free_slots;
    logic              push_a;
    logic              push_b;
    logic              pop;
    logic [ADDR_W:0]   n_push;
    logic [ADDR_W:0]   n_pop;

    logic              wen0;
    logic              wen1;
    logic [ADDR_W-1:0] waddr0;
    logic [ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0] wdest0;
    logic [DATA_W-1:0] wupd0;

    // Ready needs room for a full two-lane push, so it never looks at valids.
    assign free_slots = (ADDR_W+1)'(DEPTH) - count_q;
    assign InReady    = (free_slots >= (ADDR_W+1)'(2));

    assign push_a = InReady & InputValid_A;
    assign push_b = InReady & InputValid_B;

    assign OutValid = (count_q != '0);
    assign pop      = OutValid & OutReady;

    assign n_push = (ADDR_W+1)'(push_a) + (ADDR_W+1)'(push_b);
    assign n_pop  = (ADDR_W+1)'(pop);

    assign Count    = count_q;
    assign Overflow = overflow_q;

    assign OutDestVid = OutValid ? dest_mem[rd_ptr] : '0;
    assign OutUpdate  = OutValid ? upd_mem[rd_ptr]  : '0;

    // Lane B slides into slot 0 when lane A is idle, leaving no hole.
    always_comb begin
        wen0   = 1'b0;
        wen1   = 1'b0;
        waddr0 = wr_ptr;
        waddr1 = wr_ptr + ADDR_W'(1);
        wdest0 = InDestVid_A;
        wupd0  = InUpdate_A;
        if (push_a) begin
            wen0 = 1'b1;
            wen1 = push_b;
        end else if (push_b) begin
            wen0   = 1'b1;
            wdest0 = InDestVid_B;
            wupd0  = InUpdate_B;
        end
    end

    always_ff @(posedge clk) begin
        if (wen0) begin
            dest_mem[waddr0] <= wdest0;
            upd_mem[waddr0]  <= wupd0;
        end
        if (wen1) begin
            dest_mem[waddr1] <= InDestVid_B;
            upd_mem[waddr1]  <= InUpdate_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + n_push[ADDR_W-1:0];
            count_q <= count_q + n_push - n_pop;
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (!InReady && (InputValid_A || InputValid_B)) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_update_lane_merge.sv
// Directed-step bench for update_lane_merge with immediate assertions.
module tb_update_lane_merge;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              va, vb;
    logic [DATA_W-1:0] da, db, ua, ub;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_dest, out_upd;
    logic [ADDR_W:0]   count;
    logic              overflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    update_lane_merge #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .InputValid_A(va),
        .InputValid_B(vb),
        .InDestVid_A (da),
        .InDestVid_B (db),
        .InUpdate_A  (ua),
        .InUpdate_B  (ub),
        .InReady     (in_ready),
        .OutValid    (out_valid),
        .OutReady    (out_ready),
        .OutDestVid  (out_dest),
        .OutUpdate   (out_upd),
        .Count       (count),
        .Overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        va = 1'b0;
        vb = 1'b0;
        da = '0;
        db = '0;
        ua = '0;
        ub = '0;
    endtask

    task automatic drive(input logic a_v, input logic [31:0] a_d,
                         input logic [31:0] a_u, input logic b_v,
                         input logic [31:0] b_d, input logic [31:0] b_u);
        va = a_v;
        da = a_d;
        ua = a_u;
        vb = b_v;
        db = b_d;
        ub = b_u;
    endtask

    int got [$];
    int got_u [$];
    int k;
    int max_cnt;

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        idle_in();
        #1;

        // reset then idle
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_valid",  64'(out_valid), 64'(0));
        chk("rst_count",  64'(count),     64'(0));
        chk("rst_ready",  64'(in_ready),  64'(1));
        chk("rst_ovf",    64'(overflow),  64'(0));
        chk("rst_dest",   64'(out_dest),  64'(0));
        chk("rst_upd",    64'(out_upd),   64'(0));

        // dual push, drain
        drive(1, 5, 32'h10, 1, 9, 32'h20);
        tick();
        idle_in();
        chk("dual_count", 64'(count),     64'(2));
        chk("dual_valid", 64'(out_valid), 64'(1));
        chk("dual_h0d",   64'(out_dest),  64'(5));
        chk("dual_h0u",   64'(out_upd),   64'(32'h10));
        tick();
        chk("dual_hold",  64'(out_dest),  64'(5));
        out_ready = 1'b1;
        tick();
        chk("dual_h1d",   64'(out_dest),  64'(9));
        chk("dual_h1u",   64'(out_upd),   64'(32'h20));
        chk("dual_cnt1",  64'(count),     64'(1));
        tick();
        chk("dual_empty", 64'(out_valid), 64'(0));
        chk("dual_zd",    64'(out_dest),  64'(0));
        out_ready = 1'b0;

        // lane-B-only compaction
        drive(0, 0, 0, 1, 7, 32'h3);
        tick();
        chk("bonly_cnt1", 64'(count), 64'(1));
        drive(1, 8, 32'h4, 0, 0, 0);
        tick();
        idle_in();
        chk("bonly_cnt2", 64'(count),    64'(2));
        chk("bonly_h0d",  64'(out_dest), 64'(7));
        chk("bonly_h0u",  64'(out_upd),  64'(3));
        out_ready = 1'b1;
        tick();
        chk("bonly_h1d",  64'(out_dest), 64'(8));
        chk("bonly_h1u",  64'(out_upd),  64'(4));
        tick();
        chk("bonly_empty", 64'(out_valid), 64'(0));
        out_ready = 1'b0;

        // fill and backpressure
        for (int i = 0; i < 7; i++) begin
            drive(1, 100 + 2*i, 2*i, 1, 101 + 2*i, 2*i + 1);
            tick();
        end
        idle_in();
        chk("fill_cnt14", 64'(count),    64'(14));
        chk("fill_rdy14", 64'(in_ready), 64'(1));
        drive(1, 114, 14, 1, 115, 15);
        tick();
        chk("fill_cnt16", 64'(count),    64'(16));
        chk("fill_rdy16", 64'(in_ready), 64'(0));
        drive(1, 1, 1, 0, 0, 0);
        tick();
        idle_in();
        chk("ovf_set",    64'(overflow), 64'(1));
        chk("ovf_cnt",    64'(count),    64'(16));
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_d%0d", i), 64'(out_dest), 64'(100 + i));
            chk($sformatf("drain_u%0d", i), 64'(out_upd),  64'(i));
            tick();
            if (i == 0) begin
                chk("drain_cnt15", 64'(count),    64'(15));
                chk("drain_rdy15", 64'(in_ready), 64'(0));
            end
            if (i == 1) begin
                chk("drain_rdy14", 64'(in_ready), 64'(1));
            end
        end
        chk("drain_empty", 64'(out_valid), 64'(0));
        chk("ovf_sticky",  64'(overflow),  64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovf_clear",   64'(overflow),  64'(0));

        // wrap-around with simultaneous push/pop
        out_ready = 1'b1;
        k = 0;
        max_cnt = 0;
        for (int cyc = 0; cyc < 300 && got.size() < 80; cyc++) begin
            if (in_ready && k < 40) begin
                drive(1, 2*k, 32'hA000 + 2*k, 1, 2*k + 1, 32'hA001 + 2*k);
                k++;
            end else begin
                idle_in();
            end
            if (out_valid) begin
                got.push_back(int'(out_dest));
                got_u.push_back(int'(out_upd));
            end
            tick();
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        idle_in();
        chk("wrap_total", 64'(got.size()), 64'(80));
        for (int i = 0; i < got.size(); i++) begin
            chk($sformatf("wrap_d%0d", i), 64'(got[i]),   64'(i));
            chk($sformatf("wrap_u%0d", i), 64'(got_u[i]), 64'(32'hA000 + i));
        end
        chk("wrap_ovf",   64'(overflow),        64'(0));
        chk("wrap_max",   64'(max_cnt <= 16),   64'(1));
        chk("wrap_empty", 64'(out_valid),       64'(0));

        // reset mid-stream
        out_ready = 1'b0;
        drive(1, 1, 1, 1, 2, 2);
        tick();
        tick();
        drive(1, 5, 5, 0, 0, 0);
        tick();
        idle_in();
        chk("mid_cnt5",   64'(count), 64'(5));
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_cnt0",   64'(count),     64'(0));
        chk("mid_valid",  64'(out_valid), 64'(0));
        chk("mid_ready",  64'(in_ready),  64'(1));
        out_ready = 1'b0;
        drive(1, 32'h33, 32'h44, 0, 0, 0);
        tick();
        idle_in();
        chk("mid_headd",  64'(out_dest), 64'(32'h33));
        chk("mid_headu",  64'(out_upd),  64'(32'h44));
        chk("mid_cnt1",   64'(count),    64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
